// File: rtl/div_unit_pkg.sv
// Shared CPU definitions used by the divider, the multiplier and the control unit.
package div_unit_pkg;

    // Divider sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // R-type funct codes routed to the HI/LO arithmetic blocks
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1a;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle signed restoring divider: quotient on LO, remainder on HI.
// Operands are reduced to magnitudes at start, divided unsigned over WIDTH
// cycles, and the signs are reapplied in a single fix-up cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] DivA,
    input  logic [WIDTH-1:0] DivB,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivZero,
    output logic             DivStop
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic             div_ctrl_q;
    logic             start;
    logic             divisor_zero;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_next;

    // Operand magnitudes and one restoring-division step.  The most negative
    // value maps onto itself, which is the correct unsigned magnitude.  When
    // the trial value reaches the divisor the difference always fits in WIDTH
    // bits, so a WIDTH-bit subtract is sufficient.
    always_comb begin
        abs_a        = DivA[WIDTH-1] ? (~DivA + WIDTH'(1)) : DivA;
        abs_b        = DivB[WIDTH-1] ? (~DivB + WIDTH'(1)) : DivB;
        divisor_zero = (DivB == '0);
        trial        = {rem, dvd[WIDTH-1]};
        trial_ge     = (trial >= {1'b0, dvs});
        rem_next     = trial_ge ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];
    end

    // Next-state logic; a start is a rising edge of DivCtrl seen while idle
    always_comb begin
        state_next = state;
        start      = (state == IDLE) && DivCtrl && !div_ctrl_q;
        case (state)
            IDLE: begin
                if (start && !divisor_zero) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: operand capture, iteration registers, results and pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            div_ctrl_q <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            cnt        <= '0;
            HI         <= '0;
            LO         <= '0;
            DivZero    <= 1'b0;
            DivStop    <= 1'b0;
        end else begin
            div_ctrl_q <= DivCtrl;
            DivZero    <= 1'b0;
            DivStop    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor_zero) begin
                            DivZero <= 1'b1;
                        end else begin
                            neg_q <= DivA[WIDTH-1] ^ DivB[WIDTH-1];
                            neg_r <= DivA[WIDTH-1];
                            dvd   <= abs_a;
                            dvs   <= abs_b;
                            rem   <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    dvd <= {dvd[WIDTH-2:0], trial_ge};
                    rem <= rem_next;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    LO      <= neg_q ? (-dvd) : dvd;
                    HI      <= neg_r ? (-rem) : rem;
                    DivStop <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle signed 32-bit divider for DIV (funct 0x1a). It sits beside the ALU, downstream of the control unit, and is started by `DivCtrl`. It returns the quotient on `LO` and the remainder on `HI` to the HI/LO source muxes. It reports completion on `DivStop` and divide-by-zero on `DivZero`, both consumed by the control unit.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported in the CPU; the counter width is derived from it.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `DivCtrl` input 1: start request from the control unit; a 0→1 transition starts a division.
- `DivA` input WIDTH: dividend (register A, rs).
- `DivB` input WIDTH: divisor (register B, rt).
- `HI` output WIDTH: remainder of the last completed division.
- `LO` output WIDTH: quotient of the last completed division.
- `DivZero` output 1: one-cycle pulse when a start finds `DivB == 0`.
- `DivStop` output 1: one-cycle pulse when `HI`/`LO` hold a new result.

## Operation
- **States:** IDLE, RUN, FIX.
- **Start detection:** registered `DivCtrl_q` holds the previous value. A start occurs when state is IDLE, `DivCtrl == 1` and `DivCtrl_q == 0`. `DivCtrl` is ignored outside IDLE. Holding `DivCtrl` high never retriggers.
- **IDLE, on start:**
  - If `DivB == 0`: set `DivZero = 1`, leave `HI`/`LO` unchanged, stay in IDLE.
  - Otherwise:
    - latch `negQ = DivA[31] ^ DivB[31]` and `negR = DivA[31]`;
    - load `dvd = |DivA|` and `dvs = |DivB|`, computed with an unsigned WIDTH-bit negate (so |0x80000000| = 0x80000000 unsigned);
    - set `rem = 0`, `cnt = 0`;
    - go to RUN.
- **RUN:** one restoring-division step per cycle, 32 cycles.
  - `t = {rem[WIDTH-1:0], dvd[WIDTH-1]}`, a (WIDTH+1)-bit trial value.
  - If `t >= dvs`: `rem = t - dvs` and shift 1 into `dvd[0]`; otherwise `rem = t` and shift 0 into `dvd[0]`. `dvd` shifts left by one each cycle.
  - `cnt` increments each cycle; after the step with `cnt == WIDTH-1`, go to FIX.
- **FIX:**
  - `LO = negQ ? -dvd : dvd`.
  - `HI = negR ? -rem : rem`.
  - Negation is two's complement, truncated to WIDTH bits.
  - Set `DivStop = 1`, go to IDLE.
- **Pulse widths:** `DivStop` and `DivZero` clear to 0 on the next edge, so each is high for exactly one cycle.
- **Overflow case:** 0x80000000 / 0xFFFFFFFF gives `LO = 0x80000000`, `HI = 0`. No overflow flag is raised.
- **Outputs:** `HI`/`LO` change only in FIX and otherwise hold their value. The control unit writes them to the HI/LO registers with `HILOWrite` when it sees `DivStop`.

## Timing
- **Reset:** on an edge with `reset = 1`:
  - state = IDLE;
  - `HI = 0`, `LO = 0`, `DivZero = 0`, `DivStop = 0`;
  - `DivCtrl_q = 0`, `cnt = 0`, `rem = 0`, `dvd = 0`, `dvs = 0`.
- **Reset mid-operation:** aborts RUN/FIX with no `DivStop`. Reset has priority over start.
- **Latency:** the start is sampled at edge k. RUN occupies edges k+1..k+32; FIX occurs at edge k+33. `DivStop` is high from edge k+33 to edge k+34, with results valid in the same cycle.
- **Divide by zero:** `DivZero` is high from edge k to k+1. No `DivStop`.
- **Back-to-back:** the next start can be sampled at the earliest at edge k+34, and requires `DivCtrl` to return to 0 for at least one sampled edge.
- **Operand sampling:** `DivA`/`DivB` are sampled only at the start edge. Later changes during RUN have no effect.

## Structure
- Shared CPU package holds:
  - the state encodings (IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2);
  - the DIV/MULT funct constants (DIV = 6'h1a, MULT = 6'h18), also used by the control unit.
- Single module with no sub-module. The magnitude/negate logic is small inline combinational logic. The multiplier will be a separate sibling block with the same start/stop handshake.

## Test plan
- 100 / 7: `LO = 14`, `HI = 2`, `DivStop` high exactly 33 cycles after the start edge; `DivZero` stays 0.
- −100 (0xFFFFFF9C) / 7: `LO = −14` (0xFFFFFFF2), `HI = −2` (0xFFFFFFFE). 100 / −7: `LO = −14`, `HI = 2`.
- 0x80000000 / 0xFFFFFFFF: `LO = 0x80000000`, `HI = 0`. 0x80000000 / 1: `LO = 0x80000000`, `HI = 0`.
- 5 / 0: `DivZero` is a one-cycle pulse at the start edge, no `DivStop`, and `HI`/`LO` keep their previous values (e.g. 2 and 14).
- `DivCtrl` held high for 50 cycles: exactly one `DivStop` pulse. `DivCtrl` toggled during RUN: ignored, result unchanged.
- `reset` asserted 10 cycles into RUN: all outputs 0, no `DivStop`. A new 9 / 3 started afterwards gives `LO = 3`, `HI = 0`.
